// File: rtl/rf_ctrl_pkg.sv
// Shared register-file control definitions: requester indices and the
// writeback request record.
package rf_ctrl_pkg;

   localparam int NUM_REQ = 3;
   localparam int REQ_ALU = 0;
   localparam int REQ_LSU = 1;
   localparam int REQ_CSR = 2;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback/reservation bus between execute units, issue logic and the
// register-file write arbiter.
interface regfile_wb_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Handshake rule: a requester transfers on a cycle where its valid and
   // ready are both high at the rising edge; ready never depends on the
   // requester's own data, and valid may rise or fall freely.
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_ready;
   logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_data;

   logic              rf_write_enable;
   logic [ADDR_W-1:0] rf_write_reg;
   logic [DATA_W-1:0] rf_write_data;

   logic              reserve_valid;
   logic [ADDR_W-1:0] reserve_addr;
   logic              reserve_ready;

   logic [ADDR_W-1:0] rs_a;
   logic [ADDR_W-1:0] rs_b;
   logic              hazard_a;
   logic              hazard_b;
   logic [5:0]        pending_count;

   logic [IDX_W-1:0]  dbg_ptr;

   modport master (
      output req_valid, req_addr, req_data,
      output reserve_valid, reserve_addr, rs_a, rs_b,
      input  req_ready, rf_write_enable, rf_write_reg, rf_write_data,
      input  reserve_ready, hazard_a, hazard_b, pending_count, dbg_ptr
   );

   modport slave (
      input  req_valid, req_addr, req_data,
      input  reserve_valid, reserve_addr, rs_a, rs_b,
      output req_ready, rf_write_enable, rf_write_reg, rf_write_data,
      output reserve_ready, hazard_a, hazard_b, pending_count, dbg_ptr
   );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: search starts at ptr and wraps; ptr moves past the
// winner only when the grant is actually taken.
module rr_arbiter #(
   parameter int  NUM_REQ = 3,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               fire,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic [IDX_W-1:0]   ptr
);

   logic found;
   int   idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IDX_W'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (fire) begin
         ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter with a pending-write scoreboard that
// flags RAW/WAW hazards to the issue stage.
module regfile_wb_arbiter #(
   parameter int NUM_REQ = rf_ctrl_pkg::NUM_REQ,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5
) (
   input  logic                 clk,
   input  logic                 reset_n,
   regfile_wb_arbiter_if.slave  bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int NREGS = 2 ** ADDR_W;

   logic [NUM_REQ-1:0] req_live;
   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic [IDX_W-1:0]   arb_ptr;
   logic               fire;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;

   logic               wr_en_q;
   logic [ADDR_W-1:0]  wr_reg_q;
   logic [DATA_W-1:0]  wr_data_q;

   logic [NREGS-1:0]   pending;
   logic [NREGS-1:0]   pending_next;
   logic [5:0]         count_q;
   logic [5:0]         count_next;
   logic               res_ready;
   logic               set_bit;
   logic               clr_bit;

   // Masking requests during reset keeps any in-flight grant from firing.
   assign req_live = bus.req_valid & {NUM_REQ{reset_n}};
   assign fire     = |grant;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req_live),
      .fire      (fire),
      .grant     (grant),
      .grant_idx (grant_idx),
      .ptr       (arb_ptr)
   );

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_addr = sel_addr | bus.req_addr[i];
            sel_data = sel_data | bus.req_data[i];
         end
      end
   end

   // Writes to x0 complete the handshake but never reach the register file.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_en_q   <= 1'b0;
         wr_reg_q  <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= fire && (sel_addr != '0);
         if (fire) begin
            wr_reg_q  <= sel_addr;
            wr_data_q <= sel_data;
         end
      end
   end

   assign res_ready = reset_n & ~pending[bus.reserve_addr];
   assign set_bit   = bus.reserve_valid & res_ready & (bus.reserve_addr != '0);
   // Only a write that retires a real reservation moves the count.
   assign clr_bit   = wr_en_q & pending[wr_reg_q];

   always_comb begin
      pending_next = pending;
      if (clr_bit) pending_next[wr_reg_q] = 1'b0;
      if (set_bit) pending_next[bus.reserve_addr] = 1'b1;
      pending_next[0] = 1'b0;
   end

   always_comb begin
      count_next = count_q;
      case ({set_bit, clr_bit})
         2'b10:   count_next = count_q + 6'd1;
         2'b01:   count_next = count_q - 6'd1;
         default: count_next = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending <= '0;
         count_q <= '0;
      end else begin
         pending <= pending_next;
         count_q <= count_next;
      end
   end

   assign bus.req_ready       = grant;
   assign bus.rf_write_enable = wr_en_q;
   assign bus.rf_write_reg    = wr_reg_q;
   assign bus.rf_write_data   = wr_data_q;
   assign bus.reserve_ready   = res_ready;
   assign bus.hazard_a        = pending[bus.rs_a];
   assign bus.hazard_b        = pending[bus.rs_b];
   assign bus.pending_count   = count_q;
   assign bus.dbg_ptr         = arb_ptr;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between three writeback requesters: ALU, load/store unit and CSR unit. Also tracks which destination registers have a write outstanding, so issue logic can stall on RAW and WAW hazards. Sits between the execute-side units and the register file write port (`write_enable`/`write_reg`/`write_data`). Hazard outputs feed the issue/decode controller.

## Interface
Parameters:
- NUM_REQ, 3, number of writeback requesters (index 0 = ALU, 1 = LSU, 2 = CSR)
- DATA_W, 32, write data width
- ADDR_W, 5, register index width

Ports. One clock; reset is synchronous and active-low.
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester writeback valid
- req_ready  out  NUM_REQ  per-requester grant, one-hot or zero
- req_addr  in  NUM_REQ×ADDR_W  destination register per requester
- req_data  in  NUM_REQ×DATA_W  writeback data per requester
- rf_write_enable  out  1  register file write enable
- rf_write_reg  out  ADDR_W  register file write index
- rf_write_data  out  DATA_W  register file write data
- reserve_valid  in  1  issue stage claims a destination register
- reserve_addr  in  ADDR_W  register being claimed
- reserve_ready  out  1  claim accepted this cycle
- rs_a, rs_b  in  ADDR_W each  source registers under hazard check
- hazard_a, hazard_b  out  1 each  source has a write outstanding
- pending_count  out  6  number of registers with a write outstanding

## Operation
- Arbitration uses a round-robin pointer `ptr` (0..NUM_REQ-1). The search starts at `ptr` and wraps.
  - The first requester found with `req_valid` is granted: its `req_ready` goes high, combinationally.
  - On a handshake, `ptr` becomes the granted index + 1, mod NUM_REQ.
  - With no valid requests, `ptr` holds and all `req_ready` are 0.
- The write port is accepted every cycle, so at most one grant per cycle with no backpressure beyond arbitration.
- The granted request is captured into an output register and drives `rf_write_*` for exactly one cycle.
  - If `req_addr == 0`, the handshake still completes but `rf_write_enable` stays 0 (writes to x0 are discarded).
- Scoreboard: `pending[31:0]`; bit 0 is hard-wired to 0.
  - `reserve_ready = !pending[reserve_addr]`, which stalls on WAW. A claim of x0 is always ready and has no effect.
  - An accepted claim (`reserve_valid & reserve_ready`, addr ≠ 0) sets the bit at the next edge.
  - A cycle with `rf_write_enable` high clears `pending[rf_write_reg]` at that edge.
  - The same register cannot be set and cleared in one cycle, because of the ready rule.
- `hazard_a = pending[rs_a]` and `hazard_b = pending[rs_b]`, combinational. A source of x0 never reports a hazard.
- `pending_count` is updated incrementally: +1 on set, −1 on clear, net 0 when both happen on different registers. Its range is 0..31.

## Timing
- Reset (`reset_n` low at an edge) sets: `ptr = 0`, `pending = 0`, `pending_count = 0`, `rf_write_enable = 0`, `rf_write_reg = 0`, `rf_write_data = 0`.
  - `req_ready` and `reserve_ready` are forced to 0 while `reset_n` is low.
  - A grant or claim in flight when reset hits is dropped.
- Latency: handshake at edge N, then `rf_write_*` valid during cycle N+1, then the register file write and the scoreboard clear happen at edge N+1.
- During cycle N+1, `hazard_*` still reads 1 for that register, because the register file read returns old data. It drops in cycle N+2.
- Claim at edge N: `hazard_*` and `reserve_ready` reflect the new bit from cycle N+1.
- `pending_count` is registered and has the same timing as `pending`.

## Structure
- Shared package `rf_ctrl_pkg` holds:
  - constants `NUM_REQ`, `REQ_ALU = 0`, `REQ_LSU = 1`, `REQ_CSR = 2`;
  - `typedef struct packed {logic [4:0] addr; logic [31:0] data;} wb_req_t`.
- One sub-module, `rr_arbiter`: parameterised NUM_REQ, inputs req vector and handshake-fire, outputs one-hot grant and internal pointer.
- The scoreboard, output register and counter stay in `regfile_wb_arbiter`.

## Test plan
- Reset, then no activity: all outputs read 0. `reserve_ready` is 1 for addr 5 once `reset_n` is high.
- ALU (addr 3, 0xAAAA0001), LSU (addr 4, 0xBBBB0002) and CSR (addr 5, 0xCCCC0003) all valid continuously from `ptr = 0`.
  - Grants go 0, 1, 2 on consecutive cycles.
  - Register file writes x3, x4, x5 with those values on the next three cycles.
- LSU writes addr 0 with 0xDEADBEEF: `req_ready[1] = 1`, `rf_write_enable` stays 0, `pending_count` unchanged.
- Reserve x7:
  - `hazard_a = 1` with `rs_a = 7` from the next cycle; `pending_count = 1`.
  - A second reserve of x7 sees `reserve_ready = 0`.
  - An ALU write to x7 clears the hazard two cycles after its handshake; `pending_count = 0`.
- Simultaneous reserve x9 and writeback-clear of x7: `pending[9] = 1`, `pending[7] = 0`, `pending_count` unchanged.
- `reset_n` low while `pending = {x7, x9}` and LSU is valid: after the edge `pending_count = 0`, both hazards are 0, and no write is issued the following cycle.
